// File: rtl/histogram_stats_if.sv
// Result/stream bundle between the histogram readout and the statistics reducer.
// The readout side is the master; histogram_stats is the slave.
interface histogram_stats_if #(
    parameter int spectrumWidth = 7,
    parameter int totalWidth    = 16
);
    logic                     readingOut;
    logic [spectrumWidth-1:0] histogramValue;
    logic                     busy;
    logic                     resultValid;
    logic [spectrumWidth-1:0] peakBin;
    logic [spectrumWidth-1:0] peakCount;
    logic [totalWidth-1:0]    totalCount;
    logic                     totalSaturated;
    logic [spectrumWidth-1:0] firstBin;
    logic [spectrumWidth-1:0] lastBin;
    logic                     emptySpectrum;
    logic                     binOverflow;

    modport master (
        output readingOut, histogramValue,
        input  busy, resultValid, peakBin, peakCount, totalCount, totalSaturated,
               firstBin, lastBin, emptySpectrum, binOverflow
    );

    modport slave (
        input  readingOut, histogramValue,
        output busy, resultValid, peakBin, peakCount, totalCount, totalSaturated,
               firstBin, lastBin, emptySpectrum, binOverflow
    );
endinterface

// File: rtl/histogram_stats.sv
// Reduces one streamed histogram frame (one bin per clock) to peak, total and
// first/last non-zero bin, published with a one-cycle resultValid strobe.
module histogram_stats #(
    parameter int spectrumWidth = 7,
    parameter int totalWidth    = 16
) (
    input  logic             my_100MHz_clk,
    input  logic             reset,
    histogram_stats_if.slave hs
);
    localparam int SW = spectrumWidth;
    localparam int TW = totalWidth;
    localparam logic [SW-1:0] MAX_IDX = {SW{1'b1}};

    typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, FINISH = 2'd2} state_t;

    // MSB of the result flags that the sum clipped at all-ones.
    function automatic logic [TW:0] sat_add(input logic [TW-1:0] a, input logic [SW-1:0] b);
        logic [TW:0] s;
        s = {1'b0, a} + (TW+1)'(b);
        if (s[TW]) return {1'b1, {TW{1'b1}}};
        return s;
    endfunction

    state_t        state_q;
    logic          busy_q, result_valid_q;
    logic [SW-1:0] idx_q, acc_peak_bin_q, acc_peak_cnt_q, acc_first_q, acc_last_q;
    logic [TW-1:0] acc_total_q;
    logic          acc_sat_q, acc_seen_q, acc_ovf_q;
    logic [SW-1:0] out_peak_bin_q, out_peak_cnt_q, out_first_q, out_last_q;
    logic [TW-1:0] out_total_q;
    logic          out_sat_q, out_empty_q, out_ovf_q;

    logic [SW-1:0] value_d, nidx_d;
    logic [TW:0]   sum_d;
    logic          nz_d, start_d, accum_d;

    always_comb begin
        value_d = hs.histogramValue;
        nz_d    = (value_d != '0);
        nidx_d  = idx_q + SW'(1);
        sum_d   = sat_add(acc_total_q, value_d);
        // A frame starts from IDLE, or straight out of FINISH for back-to-back frames.
        start_d = hs.readingOut && (state_q == IDLE || state_q == FINISH);
        accum_d = hs.readingOut && (state_q == COLLECT);
    end

    always_ff @(posedge my_100MHz_clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            idx_q          <= '0;
            acc_peak_bin_q <= '0;
            acc_peak_cnt_q <= '0;
            acc_first_q    <= '0;
            acc_last_q     <= '0;
            acc_total_q    <= '0;
            acc_sat_q      <= 1'b0;
            acc_seen_q     <= 1'b0;
            acc_ovf_q      <= 1'b0;
            out_peak_bin_q <= '0;
            out_peak_cnt_q <= '0;
            out_first_q    <= '0;
            out_last_q     <= '0;
            out_total_q    <= '0;
            out_sat_q      <= 1'b0;
            out_empty_q    <= 1'b0;
            out_ovf_q      <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (hs.readingOut) begin
                        state_q <= COLLECT;
                        busy_q  <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (!hs.readingOut) state_q <= FINISH;
                end
                FINISH: begin
                    result_valid_q <= 1'b1;
                    out_total_q    <= acc_total_q;
                    out_sat_q      <= acc_sat_q;
                    out_ovf_q      <= acc_ovf_q;
                    out_empty_q    <= !acc_seen_q;
                    out_peak_bin_q <= acc_seen_q ? acc_peak_bin_q : '0;
                    out_peak_cnt_q <= acc_seen_q ? acc_peak_cnt_q : '0;
                    out_first_q    <= acc_seen_q ? acc_first_q    : '0;
                    out_last_q     <= acc_seen_q ? acc_last_q     : '0;
                    state_q        <= hs.readingOut ? COLLECT : IDLE;
                    busy_q         <= hs.readingOut;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            if (start_d) begin
                idx_q          <= '0;
                acc_peak_bin_q <= '0;
                acc_peak_cnt_q <= value_d;
                acc_total_q    <= TW'(value_d);
                acc_sat_q      <= 1'b0;
                acc_seen_q     <= nz_d;
                acc_first_q    <= '0;
                acc_last_q     <= '0;
                acc_ovf_q      <= 1'b0;
            end else if (accum_d) begin
                if (idx_q == MAX_IDX) begin
                    acc_ovf_q <= 1'b1;
                end else begin
                    idx_q       <= nidx_d;
                    acc_total_q <= sum_d[TW-1:0];
                    acc_sat_q   <= acc_sat_q | sum_d[TW];
                    if (value_d > acc_peak_cnt_q) begin
                        acc_peak_bin_q <= nidx_d;
                        acc_peak_cnt_q <= value_d;
                    end
                    if (nz_d) begin
                        if (!acc_seen_q) acc_first_q <= nidx_d;
                        acc_last_q <= nidx_d;
                        acc_seen_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign hs.busy           = busy_q;
    assign hs.resultValid    = result_valid_q;
    assign hs.peakBin        = out_peak_bin_q;
    assign hs.peakCount      = out_peak_cnt_q;
    assign hs.totalCount     = out_total_q;
    assign hs.totalSaturated = out_sat_q;
    assign hs.firstBin       = out_first_q;
    assign hs.lastBin        = out_last_q;
    assign hs.emptySpectrum  = out_empty_q;
    assign hs.binOverflow    = out_ovf_q;
endmodule
